fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end for the 5-stage LEGv8 pipeline. It sits directly upstream of the IF/ID register.
- Owns the PC and issues word reads to the instruction memory (fixed 1-cycle read latency).
- Buffers returned instructions, each paired with its PC, in a small prefetch FIFO.
- Presents them to IF/ID through a valid/ready handshake.
- A taken-branch redirect from EX/MEM flushes the buffered and in-flight fetches and restarts fetch at the target.

Parameters:
- ADDR_W, 64, PC / address width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction read strobe for this cycle.
- imem_addr  out  ADDR_W  read address; equals the PC register.
- imem_rdata  in  32  instruction word, valid the cycle after imem_req.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ins  out  32  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_ready  in  1  IF/ID accepts the head (IF/ID not stalled).
- redirect  in  1  taken branch: flush and refetch.
- redirect_pc  in  ADDR_W  branch target.
- fifo_count  out  log2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset asserted (low), asynchronously:
  - pc=RESET_PC, FIFO pointers and count=0, inflight=0, started=0.
  - Outputs: imem_req=0, out_valid=0, out_ins=0, out_pc=0, fifo_count=0.
- started is set on the first clk edge after reset deasserts; imem_req is 0 while started=0. The first request therefore goes out in the second cycle after release.
- Issue rule: imem_req = started & ~redirect & (count + inflight < DEPTH).
  - On issue: pc ← pc+4, modulo 2^ADDR_W (wraps to 0).
  - Issuing also sets inflight ← 1 and captures pc_q ← pc.
  - With no issue, inflight ← 0.
- Response: in the cycle after an issue, imem_rdata is pushed together with pc_q, unless a redirect occurs that cycle. Latency from issue to out_valid is 2 cycles; no bypass path, the output is always the FIFO head.
- Pop: out_valid & out_ready, at the clock edge. Push and pop in the same cycle leave the count unchanged.
- Overflow is impossible by construction because issue is gated on count+inflight. Pop when empty is ignored.
- Throughput is one instruction per cycle while out_ready=1.
- Redirect (highest priority):
  - FIFO cleared (count=0, pointers=0) and any in-flight response discarded (no push).
  - A pop in the same cycle is ignored.
  - pc ← {redirect_pc[ADDR_W-1:2], 2'b00}; no request that cycle.
  - The target is requested in the next cycle. Back-to-back redirects: the last one wins.
- out_ins and out_pc hold their last value when out_valid=0; they return to 0 only on reset or flush.
- fifo_count reflects the registered count.

Test Plan:
1. Reset release, out_ready=0, imem returns addr>>2 as data:
   - imem_req asserts at addresses 0x0, 0x4, 0x8, 0xC, then drops.
   - fifo_count reaches 4; out_ins=0, out_pc=0; imem_req stays 0.
2. From full, set out_ready=1:
   - Heads appear with out_pc 0x0, 0x4, 0x8, … in consecutive cycles, one per cycle with no bubbles.
   - imem_req resumes 1 cycle after the first pop.
3. Redirect to 0x100 in the cycle after a request to 0x10:
   - The 0x10 response is dropped and fifo_count=0.
   - Next imem_addr=0x100; out_valid=1 with out_pc=0x100 two cycles later.
4. Redirect with redirect_pc=0x203, asserted together with out_valid & out_ready:
   - Pop ignored, FIFO empty.
   - Next request at 0x200.
5. RESET_PC=0xFFFF_FFFF_FFFF_FFFC, straight-line fetch:
   - Second request address is 0x0.
   - out_pc sequence is 0x…FFFC, then 0x0.
6. Reset asserted mid-stream with FIFO at 3 and a request in flight:
   - All outputs go to 0 immediately, with no clock needed.
   - After release, fetch restarts at RESET_PC; no stale instruction is pushed.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: LEGv8 instruction-fetch front end. It owns the PC, keeps a      |
// | prefetch FIFO and redirects on taken branches. Rev 1.0                      |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic                      out_valid,
  output logic [31:0]               out_ins,
  output logic [ADDR_W-1:0]         out_pc,
  input  logic                      out_ready,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;
  localparam int unsigned c_OCC_W = c_CNT_W + 1;
  localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_q;
  logic               r_inflight;
  logic               r_started;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [31:0]        r_out_ins;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [31:0]        r_mem_ins [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc  [DEPTH];

  logic [c_OCC_W-1:0] w_occ;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [c_PTR_W-1:0] w_rd_next;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [31:0]        w_head_ins;
  logic [ADDR_W-1:0]  w_head_pc;
  logic               w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  always_comb begin
    w_occ      = c_OCC_W'(r_count) + c_OCC_W'(r_inflight);
    w_issue    = r_started & ~redirect & (w_occ < c_DEPTH);
    w_push     = r_inflight & ~redirect;
    w_pop      = (r_count != '0) & out_ready & ~redirect;
    w_rd_next  = r_rd_ptr + c_PTR_W'(w_pop);
    w_cnt_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    // The head after this edge is the entry being pushed when the FIFO drains to it.
    w_head_ins = r_mem_ins[w_rd_next];
    w_head_pc  = r_mem_pc[w_rd_next];
    if ((r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop)) begin
      w_head_ins = imem_rdata;
      w_head_pc  = r_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_pc_q     <= '0;
      r_inflight <= 1'b0;
      r_started  <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_ins  <= '0;
      r_out_pc   <= '0;
    end else begin
      r_started <= 1'b1;
      if (redirect) begin
        r_pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_out_ins  <= '0;
        r_out_pc   <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc   <= r_pc + ADDR_W'(4);
          r_pc_q <= r_pc;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        r_rd_ptr <= w_rd_next;
        r_count  <= w_cnt_next;
        // Output registers hold the last head while the FIFO is empty.
        if (w_cnt_next != '0) begin
          r_out_ins <= w_head_ins;
          r_out_pc  <= w_head_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ins[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]  <= r_pc_q;
    end
  end

  assign imem_req   = w_issue;
  assign imem_addr  = r_pc;
  assign out_valid  = (r_count != '0);
  assign out_ins    = r_out_ins;
  assign out_pc     = r_out_pc;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: directed vector table, wrap-around instance,
// randomized traffic against a queue-based model, and mid-stream reset.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        out_ready, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] salt;

  logic        imem_req, out_valid;
  logic [63:0] imem_addr, out_pc;
  logic [31:0] imem_rdata, out_ins;
  logic [2:0]  fifo_count;

  logic        w_req, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_rdata, w_ins;
  logic [2:0]  w_count;

  fetch_unit #(.ADDR_W(64), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ins(out_ins),
    .out_pc(out_pc), .out_ready(out_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .fifo_count(fifo_count));

  fetch_unit #(.ADDR_W(64), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .out_valid(w_valid), .out_ins(w_ins),
    .out_pc(w_pc), .out_ready(1'b1), .redirect(1'b0),
    .redirect_pc(64'h0), .fifo_count(w_count));

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ salt;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= mem_word(imem_addr);
    w_rdata    <= mem_word(w_addr);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of {instruction, pc} plus one pending response.
  typedef struct { logic [31:0] ins; logic [63:0] pc; } ent_t;
  ent_t        m_q[$];
  ent_t        m_pend_e, m_last;
  bit          m_pend, m_started;
  logic [63:0] m_pc;

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_started = 0; m_pc = 64'h0;
    m_last = '{32'h0, 64'h0};
    m_pend_e = '{32'h0, 64'h0};
  endtask

  function automatic bit m_req();
    return m_started && !redirect && ((m_q.size() + int'(m_pend)) < DEPTH);
  endfunction

  task automatic model_check();
    chk("req",   64'(imem_req),   64'(m_req()));
    chk("addr",  imem_addr,       m_pc);
    chk("valid", 64'(out_valid),  64'(m_q.size() != 0));
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    chk("ins",   64'(out_ins),    64'(m_last.ins));
    chk("pc",    out_pc,          m_last.pc);
  endtask

  task automatic model_step();
    bit req;
    req = m_req();
    if (redirect) begin
      m_q.delete();
      m_pend = 0;
      m_pc = {redirect_pc[63:2], 2'b00};
      m_last = '{32'h0, 64'h0};
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_e);
      m_pend = req;
      if (req) begin
        m_pend_e = '{mem_word(m_pc), m_pc};
        m_pc = m_pc + 64'd4;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
    m_started = 1;
  endtask

  task automatic drive(input logic r, input logic rd, input logic [63:0] rp, input logic [31:0] s);
    @(negedge clk);
    out_ready = r; redirect = rd; redirect_pc = rp; salt = s;
    #1;
  endtask

  task automatic cyc(input logic r, input logic rd, input logic [63:0] rp, input logic [31:0] s);
    drive(r, rd, rp, s);
    model_check();
    model_step();
  endtask

  typedef struct {
    logic rdy; logic rd; logic [63:0] rpc;
    logic req; logic [63:0] addr; logic vld; logic [63:0] pc; logic [2:0] cnt;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // rdy rd  rpc        req addr      vld pc        cnt
    tbl[0]  = '{0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   3'd0};
    tbl[1]  = '{0, 0, 64'h0,   1, 64'h0,   0, 64'h0,   3'd0};
    tbl[2]  = '{0, 0, 64'h0,   1, 64'h4,   0, 64'h0,   3'd0};
    tbl[3]  = '{0, 0, 64'h0,   1, 64'h8,   1, 64'h0,   3'd1};
    tbl[4]  = '{0, 0, 64'h0,   1, 64'hC,   1, 64'h0,   3'd2};
    tbl[5]  = '{0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd3};
    tbl[6]  = '{0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4};
    tbl[7]  = '{0, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4};
    tbl[8]  = '{1, 0, 64'h0,   0, 64'h10,  1, 64'h0,   3'd4};
    tbl[9]  = '{1, 0, 64'h0,   1, 64'h10,  1, 64'h4,   3'd3};
    tbl[10] = '{1, 1, 64'h100, 0, 64'h14,  1, 64'h8,   3'd2};
    tbl[11] = '{1, 0, 64'h0,   1, 64'h100, 0, 64'h0,   3'd0};
    tbl[12] = '{1, 0, 64'h0,   1, 64'h104, 0, 64'h0,   3'd0};
    tbl[13] = '{1, 1, 64'h203, 0, 64'h108, 1, 64'h100, 3'd1};
    tbl[14] = '{0, 0, 64'h0,   1, 64'h200, 0, 64'h0,   3'd0};
    tbl[15] = '{0, 0, 64'h0,   1, 64'h204, 0, 64'h0,   3'd0};
    tbl[16] = '{0, 0, 64'h0,   1, 64'h208, 1, 64'h200, 3'd1};

    reset = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; salt = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   64'(imem_req),   64'h0);
    chk("rst_addr",  imem_addr,       64'h0);
    chk("rst_valid", 64'(out_valid),  64'h0);
    chk("rst_ins",   64'(out_ins),    64'h0);
    chk("rst_pc",    out_pc,          64'h0);
    chk("rst_count", 64'(fifo_count), 64'h0);
    chk("rst_waddr", w_addr,          WRAP_PC);

    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rdy, tbl[i].rd, tbl[i].rpc, 32'h0);
      chk($sformatf("tbl%0d_req", i),   64'(imem_req),   64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i),  imem_addr,       tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid),  64'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i),    out_pc,          tbl[i].pc);
      chk($sformatf("tbl%0d_ins", i),   64'(out_ins),    tbl[i].pc >> 2);
      chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].cnt));
      if (i == 1) chk("wrap_addr0", w_addr, WRAP_PC);
      if (i == 2) chk("wrap_addr1", w_addr, 64'h0);
      if (i == 3) chk("wrap_pc0", w_pc, WRAP_PC);
      if (i == 4) chk("wrap_pc1", w_pc, 64'h0);
      model_step();
    end

    repeat (400) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
          {$urandom, $urandom}, $urandom);
    end

    // Fill to three entries with one response in flight, then reset asynchronously.
    cyc(1'b0, 1'b1, 64'h1000, 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 64'h0, 32'h0);
    drive(1'b0, 1'b0, 64'h0, 32'h0);
    model_check();
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    #1 reset = 1'b0;
    #1;
    chk("async_req",   64'(imem_req),   64'h0);
    chk("async_addr",  imem_addr,       64'h0);
    chk("async_valid", 64'(out_valid),  64'h0);
    chk("async_ins",   64'(out_ins),    64'h0);
    chk("async_pc",    out_pc,          64'h0);
    chk("async_count", 64'(fifo_count), 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (12) cyc(1'b1, 1'b0, 64'h0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
